universal_shift_register: RTL and testbench

//   Parametrised WIDTH-bit register with parallel load, clear and multi-cycle

---
 rtl/universal_shift_register.sv | 126 ++++++++++++
 tb/tb_universal_shift_register.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal register: parallel load, clear and multi-cycle shift/rotate
// sequences started by a one-cycle command, with busy/done progress flags.
module universal_shift_register #(
    parameter int               WIDTH     = 8,
    parameter int               AMT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_ASR   = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e           state, state_nxt;
    op_e              op_q, op_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;

    function automatic logic [WIDTH-1:0] step(input op_e op, input logic [WIDTH-1:0] v,
                                              input logic s);
        case (op)
            OP_SHL:  return {v[WIDTH-2:0], s};
            OP_SHR:  return {s, v[WIDTH-1:1]};
            OP_ROL:  return {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  return {v[0], v[WIDTH-1:1]};
            OP_ASR:  return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return v;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= OP_HOLD;
            count <= '0;
            q     <= RESET_VAL;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            count <= count_nxt;
            q     <= q_nxt;
            done  <= done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        count_nxt = count;
        q_nxt     = q;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op_e'(mode))
                        OP_HOLD: done_nxt = 1'b1;
                        OP_LOAD: begin
                            q_nxt    = din;
                            done_nxt = 1'b1;
                        end
                        OP_CLEAR: begin
                            q_nxt    = '0;
                            done_nxt = 1'b1;
                        end
                        default: begin
                            // A zero-length shift completes immediately like HOLD.
                            if (amount == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                op_nxt    = op_e'(mode);
                                count_nxt = amount;
                                state_nxt = S_RUN;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                q_nxt     = step(op_q, q, sin);
                count_nxt = count - AMT_W'(1);
                if (count == AMT_W'(1)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_RUN);
        sout_msb = q[WIDTH-1];
        sout_lsb = q[0];
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised self-checking bench for universal_shift_register (WIDTH=8, AMT_W=4),
// compared against an arithmetic reference model of each command.
module tb_universal_shift_register;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode = '0;
    logic [3:0] amount = '0;
    logic [7:0] din = '0;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout_msb, sout_lsb, busy, done;

    int tests = 0;
    int fails = 0;
    logic [7:0] mq = 8'h00;

    universal_shift_register #(.WIDTH(8), .AMT_W(4), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
        .din(din), .sin(sin), .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Final register value of a whole command, from plain integer arithmetic.
    function automatic logic [7:0] model(input logic [2:0] m, input int n, input logic [7:0] d,
                                         input logic s, input logic [7:0] cur);
        int v;
        int k;
        logic signed [7:0] sv;
        v = int'(cur);
        if (m == M_HOLD) return cur;
        if (m == M_LOAD) return d;
        if (m == M_CLEAR) return 8'h00;
        if (n == 0) return cur;
        case (m)
            M_SHL: begin
                if (n >= 8) return {8{s}};
                return 8'(((v << n) & 255) | (s ? ((1 << n) - 1) : 0));
            end
            M_SHR: begin
                if (n >= 8) return {8{s}};
                return 8'((v >> n) | (s ? (255 & ~(255 >> n)) : 0));
            end
            M_ROL: begin
                k = n % 8;
                return 8'(((v << k) | (v >> (8 - k))) & 255);
            end
            M_ROR: begin
                k = n % 8;
                return 8'(((v >> k) | (v << (8 - k))) & 255);
            end
            default: begin
                sv = $signed(cur);
                return 8'(sv >>> n);
            end
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] m, input int n);
        if (m == M_HOLD || m == M_LOAD || m == M_CLEAR) return 0;
        return n;
    endfunction

    // Issues one command at a negedge and returns at the negedge where done is seen.
    // Inputs other than sin are scrambled during the sequence; the DUT must ignore them.
    task automatic run_cmd(input logic [2:0] m, input logic [3:0] n, input logic [7:0] d,
                           input logic s, output int cycles, output int busy_cnt);
        start  = 1'b1;
        mode   = m;
        amount = n;
        din    = d;
        sin    = s;
        @(negedge clk);
        start    = 1'b0;
        mode     = 3'($urandom);
        amount   = 4'($urandom);
        din      = 8'($urandom);
        cycles   = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        if (busy === 1'b1) busy_cnt++;
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL cmd_timeout mode=%b amount=%0d: done not seen within %0d cycles",
                     m, n, cycles);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        mode  = M_LOAD;
        din   = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (q !== 8'h00 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle q=%h done=%b, want q=00 done=0", q, done);
        end
        mq = 8'h00;
    endtask

    task automatic test_load();
        int c, b;
        run_cmd(M_LOAD, 4'd0, 8'hA5, 1'b0, c, b);
        mq = 8'hA5;
        tests++;
        if (q !== 8'hA5 || c != 1 || b != 0) begin
            fails++;
            $display("FAIL load q=%h cycles=%0d busy=%0d, want q=a5 cycles=1 busy=0", q, c, b);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || q !== 8'hA5) begin
            fails++;
            $display("FAIL load_pulse done=%b q=%h, want done=0 q=a5", done, q);
        end
    endtask

    task automatic test_rotate();
        int c, b;
        run_cmd(M_ROL, 4'd3, 8'h00, 1'b0, c, b);
        mq = model(M_ROL, 3, 8'h00, 1'b0, mq);
        tests++;
        if (q !== 8'h2D || q !== mq || c != 4 || b != 3) begin
            fails++;
            $display("FAIL rol3 q=%h cycles=%0d busy=%0d, want q=2d cycles=4 busy=3", q, c, b);
        end
        run_cmd(M_LOAD, 4'd0, 8'hA5, 1'b0, c, b);
        run_cmd(M_ROR, 4'd11, 8'h00, 1'b0, c, b);
        mq = model(M_ROR, 3, 8'h00, 1'b0, 8'hA5);
        tests++;
        if (q !== mq || q !== 8'hB4 || c != 12 || b != 11) begin
            fails++;
            $display("FAIL ror11 q=%h cycles=%0d busy=%0d, want q=%h cycles=12 busy=11", q, c, b, mq);
        end
    endtask

    task automatic test_shifts();
        int c, b;
        run_cmd(M_LOAD, 4'd0, 8'h80, 1'b0, c, b);
        run_cmd(M_ASR, 4'd2, 8'h00, 1'b0, c, b);
        tests++;
        if (q !== 8'hE0 || b != 2) begin
            fails++;
            $display("FAIL asr2 q=%h busy=%0d, want q=e0 busy=2", q, b);
        end
        run_cmd(M_CLEAR, 4'd0, 8'h00, 1'b0, c, b);
        run_cmd(M_SHR, 4'd8, 8'h00, 1'b1, c, b);
        tests++;
        if (q !== 8'hFF || b != 8 || sout_lsb !== 1'b1) begin
            fails++;
            $display("FAIL shr8_sin1 q=%h busy=%0d lsb=%b, want q=ff busy=8 lsb=1", q, b, sout_lsb);
        end
        run_cmd(M_SHL, 4'd10, 8'h00, 1'b0, c, b);
        tests++;
        if (q !== 8'h00 || b != 10 || c != 11) begin
            fails++;
            $display("FAIL shl10_sin0 q=%h busy=%0d cycles=%0d, want q=00 busy=10 cycles=11", q, b, c);
        end
        mq = 8'h00;
    endtask

    task automatic test_collisions();
        int c, b, n;
        run_cmd(M_LOAD, 4'd0, 8'hA5, 1'b0, c, b);
        start  = 1'b1;
        mode   = M_ROL;
        amount = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mode  = M_LOAD;
        din   = 8'h11;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        mq = model(M_ROL, 5, 8'h00, 1'b0, 8'hA5);
        tests++;
        if (q !== mq || done !== 1'b1) begin
            fails++;
            $display("FAIL start_while_busy q=%h done=%b, want q=%h done=1", q, done, mq);
        end
        @(negedge clk);
        tests++;
        if (q !== mq || done !== 1'b0) begin
            fails++;
            $display("FAIL ignored_load q=%h done=%b, want q=%h done=0", q, done, mq);
        end
        start  = 1'b1;
        mode   = M_ROR;
        amount = 4'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_seq q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
        end
        run_cmd(M_LOAD, 4'd0, 8'h3C, 1'b0, c, b);
        mq = 8'h3C;
        tests++;
        if (q !== 8'h3C || c != 1) begin
            fails++;
            $display("FAIL cmd_after_reset q=%h cycles=%0d, want q=3c cycles=1", q, c);
        end
    endtask

    task automatic test_edge_cases();
        int c, b;
        run_cmd(M_SHL, 4'd0, 8'h00, 1'b1, c, b);
        tests++;
        if (q !== mq || c != 1 || b != 0) begin
            fails++;
            $display("FAIL shift_amount0 q=%h cycles=%0d busy=%0d, want q=%h cycles=1 busy=0", q, c, b, mq);
        end
        run_cmd(M_HOLD, 4'd7, 8'hFF, 1'b1, c, b);
        tests++;
        if (q !== mq || c != 1 || b != 0) begin
            fails++;
            $display("FAIL hold q=%h cycles=%0d busy=%0d, want q=%h cycles=1 busy=0", q, c, b, mq);
        end
        run_cmd(M_CLEAR, 4'd0, 8'h00, 1'b0, c, b);
        mq = 8'h00;
        tests++;
        if (q !== 8'h00 || c != 1) begin
            fails++;
            $display("FAIL clear q=%h cycles=%0d, want q=00 cycles=1", q, c);
        end
    endtask

    task automatic test_back_to_back();
        int c, b;
        run_cmd(M_LOAD, 4'd0, 8'h81, 1'b0, c, b);
        tests++;
        if (q !== 8'h81 || done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_load q=%h done=%b, want q=81 done=1", q, done);
        end
        run_cmd(M_ROL, 4'd1, 8'h00, 1'b0, c, b);
        mq = model(M_ROL, 1, 8'h00, 1'b0, 8'h81);
        tests++;
        if (q !== mq || c != 2 || b != 1) begin
            fails++;
            $display("FAIL b2b_rol1 q=%h cycles=%0d busy=%0d, want q=%h cycles=2 busy=1", q, c, b, mq);
        end
    endtask

    task automatic test_random();
        int c, b, gap;
        logic [2:0] m;
        logic [3:0] n;
        logic [7:0] d;
        logic       s;
        for (int i = 0; i < 40; i++) begin
            m  = 3'($urandom);
            n  = 4'($urandom);
            d  = 8'($urandom);
            s  = 1'($urandom);
            run_cmd(m, n, d, s, c, b);
            mq = model(m, int'(n), d, s, mq);
            tests++;
            if (q !== mq || sout_msb !== mq[7] || sout_lsb !== mq[0]) begin
                fails++;
                $display("FAIL rand_q[%0d] mode=%b n=%0d q=%h msb=%b lsb=%b, want q=%h", i, m, n, q,
                         sout_msb, sout_lsb, mq);
            end
            tests++;
            if (b != exp_busy(m, int'(n)) || c != exp_busy(m, int'(n)) + 1) begin
                fails++;
                $display("FAIL rand_timing[%0d] mode=%b n=%0d busy=%0d cycles=%0d, want busy=%0d cycles=%0d",
                         i, m, n, b, c, exp_busy(m, int'(n)), exp_busy(m, int'(n)) + 1);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                tests++;
                if (q !== mq || done !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_idle[%0d] q=%h done=%b busy=%b, want q=%h done=0 busy=0", i, q,
                             done, busy, mq);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rotate();
        test_shifts();
        test_collisions();
        test_edge_cases();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
